// File: rtl/sqrt_sched_pkg.sv
// rtl/sqrt_sched_pkg.sv - shared state encoding, defaults and helpers for the sqrt scheduler
package sqrt_sched_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_TIMEOUT = 64;

    // Gray-ordered so IDLE->START->WAIT->RESP changes one bit per step
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_WAIT  = 2'b11,
        ST_RESP  = 2'b10
    } state_t;

    function automatic logic [1:0] owner_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sqrt_scheduler_if.sv
// rtl/sqrt_scheduler_if.sv - requester, response and datapath signals of the sqrt scheduler
interface sqrt_scheduler_if
    import sqrt_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [1:0]         req_i;
    logic [WIDTH-1:0]   op0_i;
    logic [WIDTH-1:0]   op1_i;
    logic [1:0]         gnt_o;
    logic [1:0]         rsp_valid_o;
    logic [1:0]         rsp_ack_i;
    logic [WIDTH/2-1:0] rsp_root_o;
    logic               rsp_err_o;
    logic               core_start_o;
    logic [WIDTH-1:0]   core_op_o;
    logic               core_done_i;
    logic [WIDTH/2-1:0] core_root_i;
    logic               core_abort_o;

    modport master (
        output req_i, op0_i, op1_i, rsp_ack_i, core_done_i, core_root_i,
        input  gnt_o, rsp_valid_o, rsp_root_o, rsp_err_o,
               core_start_o, core_op_o, core_abort_o
    );

    modport slave (
        input  req_i, op0_i, op1_i, rsp_ack_i, core_done_i, core_root_i,
        output gnt_o, rsp_valid_o, rsp_root_o, rsp_err_o,
               core_start_o, core_op_o, core_abort_o
    );

endinterface

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-way round-robin arbiter, combinational one-hot grant
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // on a tie the requester not served last wins
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/sqrt_scheduler.sv
// rtl/sqrt_scheduler.sv - two-requester scheduler in front of a square-root datapath
module sqrt_scheduler
    import sqrt_sched_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    sqrt_scheduler_if.slave  bus
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t           state;
    logic             last;
    logic             owner;
    logic [CW-1:0]    cnt;
    logic [1:0]       grant;
    logic [WIDTH-1:0] op_sel;

    rr_arbiter_2 u_arb (
        .req   (bus.req_i),
        .last  (last),
        .grant (grant)
    );

    always_comb begin
        op_sel = grant[1] ? bus.op1_i : bus.op0_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            last             <= 1'b1;
            owner            <= 1'b0;
            cnt              <= '0;
            bus.gnt_o        <= 2'b00;
            bus.rsp_valid_o  <= 2'b00;
            bus.rsp_root_o   <= '0;
            bus.rsp_err_o    <= 1'b0;
            bus.core_start_o <= 1'b0;
            bus.core_op_o    <= '0;
            bus.core_abort_o <= 1'b0;
        end else begin
            bus.gnt_o        <= 2'b00;
            bus.core_start_o <= 1'b0;
            bus.core_abort_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        owner            <= grant[1];
                        last             <= grant[1];
                        bus.core_op_o    <= op_sel;
                        bus.gnt_o        <= grant;
                        bus.core_start_o <= 1'b1;
                        state            <= ST_START;
                    end
                end
                ST_START: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // completion takes priority over a coincident timeout
                    if (bus.core_done_i) begin
                        bus.rsp_root_o  <= bus.core_root_i;
                        bus.rsp_err_o   <= 1'b0;
                        bus.rsp_valid_o <= owner_onehot(owner);
                        state           <= ST_RESP;
                    end else if (cnt == CNT_LAST) begin
                        bus.core_abort_o <= 1'b1;
                        bus.rsp_root_o   <= '0;
                        bus.rsp_err_o    <= 1'b1;
                        bus.rsp_valid_o  <= owner_onehot(owner);
                        state            <= ST_RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ack_i[owner]) begin
                        bus.rsp_valid_o <= 2'b00;
                        state           <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_scheduler.sv
// tb/tb_sqrt_scheduler.sv - self-checking bench for sqrt_scheduler
module tb_sqrt_scheduler;
    import sqrt_sched_pkg::*;

    localparam int W   = 8;
    localparam int HW  = W / 2;
    localparam int TO  = 64;
    localparam int NEVER = 1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sqrt_scheduler_if #(.WIDTH(W)) bus ();

    sqrt_scheduler #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    bit m_last = 1'b1;

    typedef struct {
        logic [1:0]    gnt;
        logic          start;
        logic [W-1:0]  op;
        logic [1:0]    valid;
        logic [HW-1:0] root;
        logic          err;
        int            aborts;
        int            waits;
        int            vcycles;
        bit            dropped;
        bit            lost;
    } res_t;

    function automatic int isqrt(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    function automatic logic [1:0] model_pick(input logic [1:0] req);
        if (req == 2'b11) return m_last ? 2'b01 : 2'b10;
        return req;
    endfunction

    task automatic run_txn(input logic [1:0] req, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int dly, input int ackd, input bit spur, input bit hold,
                           output res_t r);
        int k;
        logic ob;
        r.gnt = 0; r.start = 0; r.op = 0; r.valid = 0; r.root = 0; r.err = 0;
        r.aborts = 0; r.waits = 0; r.vcycles = 0; r.dropped = 0; r.lost = 0;
        bus.req_i = req; bus.op0_i = a; bus.op1_i = b;
        k = 0;
        while (bus.gnt_o == 2'b00 && k < 8) begin
            @(negedge clk);
            k++;
        end
        if (bus.gnt_o == 2'b00) begin
            tests++; fails++; r.lost = 1;
            $display("FAIL grant_timeout got gnt %b want nonzero", bus.gnt_o);
            bus.req_i = 0;
            return;
        end
        r.gnt = bus.gnt_o; r.start = bus.core_start_o; r.op = bus.core_op_o;
        k = 0;
        while (k < TO + 8) begin
            @(negedge clk);
            k++;
            bus.core_done_i = 1'b0;
            if (bus.core_abort_o) r.aborts++;
            if (bus.rsp_valid_o != 2'b00) break;
            if (k - 1 == dly) begin
                bus.core_done_i = 1'b1;
                bus.core_root_i = HW'(isqrt(int'(r.op)));
            end
        end
        if (bus.rsp_valid_o == 2'b00) begin
            tests++; fails++; r.lost = 1;
            $display("FAIL response_timeout got valid %b want nonzero", bus.rsp_valid_o);
            bus.req_i = 0;
            return;
        end
        r.waits = k - 1; r.valid = bus.rsp_valid_o; r.root = bus.rsp_root_o; r.err = bus.rsp_err_o;
        r.vcycles = 1;
        ob = r.gnt[1];
        for (int j = 0; j < ackd; j++) begin
            if (spur) begin
                bus.rsp_ack_i   = ob ? 2'b01 : 2'b10;
                bus.core_done_i = 1'b1;
                bus.core_root_i = '1;
            end
            @(negedge clk);
            bus.rsp_ack_i = 2'b00; bus.core_done_i = 1'b0;
            if (bus.core_abort_o) r.aborts++;
            if (bus.rsp_valid_o == r.valid && bus.rsp_root_o == r.root) r.vcycles++;
        end
        bus.rsp_ack_i = ob ? 2'b10 : 2'b01;
        if (!hold) bus.req_i = 2'b00;
        @(negedge clk);
        bus.rsp_ack_i = 2'b00;
        if (bus.core_abort_o) r.aborts++;
        r.dropped = (bus.rsp_valid_o == 2'b00);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_i = 2'b01; bus.op0_i = 8'd99;
        repeat (3) @(negedge clk);
        tests++; if (bus.gnt_o !== 2'b00 || bus.core_start_o !== 1'b0) begin fails++; $display("FAIL reset_gnt got gnt %b start %b want 00 0", bus.gnt_o, bus.core_start_o); end
        tests++; if (bus.rsp_valid_o !== 2'b00 || bus.rsp_err_o !== 1'b0) begin fails++; $display("FAIL reset_rsp got valid %b err %b want 00 0", bus.rsp_valid_o, bus.rsp_err_o); end
        tests++; if (bus.rsp_root_o !== '0 || bus.core_op_o !== '0) begin fails++; $display("FAIL reset_data got root %0d op %0d want 0 0", bus.rsp_root_o, bus.core_op_o); end
        tests++; if (bus.core_abort_o !== 1'b0) begin fails++; $display("FAIL reset_abort got %b want 0", bus.core_abort_o); end
        bus.req_i = 2'b00;
        rst = 1'b0;
        m_last = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_tie();
        res_t r;
        logic [1:0] want;
        logic [W-1:0] wop;
        for (int i = 0; i < 2; i++) begin
            want = model_pick(2'b11);
            wop  = want[1] ? 8'd81 : 8'd16;
            run_txn(2'b11, 8'd16, 8'd81, 1, 0, 0, 0, r);
            if (r.lost) continue;
            tests++; if (r.gnt !== want) begin fails++; $display("FAIL tie_gnt[%0d] got %b want %b", i, r.gnt, want); end
            tests++; if (r.root !== HW'(isqrt(int'(wop)))) begin fails++; $display("FAIL tie_root[%0d] got %0d want %0d", i, r.root, isqrt(int'(wop))); end
            tests++; if (r.valid !== want) begin fails++; $display("FAIL tie_valid[%0d] got %b want %b", i, r.valid, want); end
            m_last = want[1];
        end
    endtask

    task automatic test_basic();
        res_t r;
        run_txn(2'b01, 8'd49, 8'd0, 2, 0, 0, 0, r);
        if (r.lost) return;
        tests++; if (r.gnt !== 2'b01 || r.start !== 1'b1) begin fails++; $display("FAIL basic_gnt got gnt %b start %b want 01 1", r.gnt, r.start); end
        tests++; if (r.op !== 8'd49) begin fails++; $display("FAIL basic_op got %0d want 49", r.op); end
        tests++; if (r.valid !== 2'b01 || r.root !== 4'd7 || r.err !== 1'b0) begin fails++; $display("FAIL basic_rsp got valid %b root %0d err %b want 01 7 0", r.valid, r.root, r.err); end
        tests++; if (r.waits !== 3) begin fails++; $display("FAIL basic_latency got %0d wait cycles want 3", r.waits); end
        tests++; if (!r.dropped || r.aborts != 0) begin fails++; $display("FAIL basic_end got dropped %0d aborts %0d want 1 0", r.dropped, r.aborts); end
        m_last = 1'b0;
    endtask

    task automatic test_alternate();
        res_t r;
        logic [1:0] want;
        logic [1:0] prev = 2'b00;
        for (int i = 0; i < 4; i++) begin
            want = model_pick(2'b11);
            run_txn(2'b11, 8'd100, 8'd225, 0, 0, 0, (i < 3), r);
            if (r.lost) continue;
            tests++; if (r.gnt !== want || r.gnt === prev) begin fails++; $display("FAIL alt_gnt[%0d] got %b want %b", i, r.gnt, want); end
            tests++; if (r.root !== (want[1] ? 4'd15 : 4'd10)) begin fails++; $display("FAIL alt_root[%0d] got %0d want %0d", i, r.root, want[1] ? 15 : 10); end
            prev = r.gnt;
            m_last = want[1];
        end
    endtask

    task automatic test_timeout();
        res_t r;
        run_txn(2'b01, 8'd200, 8'd0, NEVER, 1, 0, 0, r);
        if (!r.lost) begin
            tests++; if (r.aborts != 1) begin fails++; $display("FAIL to_abort got %0d abort cycles want 1", r.aborts); end
            tests++; if (r.err !== 1'b1 || r.root !== '0 || r.valid !== 2'b01) begin fails++; $display("FAIL to_rsp got err %b root %0d valid %b want 1 0 01", r.err, r.root, r.valid); end
            tests++; if (r.waits != TO) begin fails++; $display("FAIL to_waits got %0d want %0d", r.waits, TO); end
            m_last = 1'b0;
        end
        run_txn(2'b10, 8'd0, 8'd200, TO - 1, 0, 0, 0, r);
        if (!r.lost) begin
            tests++; if (r.aborts != 0 || r.err !== 1'b0) begin fails++; $display("FAIL edge_done got aborts %0d err %b want 0 0", r.aborts, r.err); end
            tests++; if (r.root !== 4'd14 || r.waits != TO) begin fails++; $display("FAIL edge_root got root %0d waits %0d want 14 %0d", r.root, r.waits, TO); end
            m_last = 1'b1;
        end
    endtask

    task automatic test_ack_delay();
        res_t r;
        run_txn(2'b10, 8'd3, 8'd144, 1, 10, 1, 0, r);
        if (r.lost) return;
        tests++; if (r.valid !== 2'b10 || r.root !== 4'd12) begin fails++; $display("FAIL ackd_rsp got valid %b root %0d want 10 12", r.valid, r.root); end
        tests++; if (r.vcycles != 11) begin fails++; $display("FAIL ackd_hold got %0d stable valid cycles want 11", r.vcycles); end
        tests++; if (!r.dropped) begin fails++; $display("FAIL ackd_drop got valid still high want dropped"); end
        m_last = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        res_t r;
        int k = 0;
        bit bad = 0;
        bus.req_i = 2'b01; bus.op0_i = 8'd200;
        while (bus.gnt_o == 2'b00 && k < 8) begin @(negedge clk); k++; end
        tests++; if (bus.gnt_o !== 2'b01) begin fails++; $display("FAIL rmw_gnt got %b want 01", bus.gnt_o); end
        bus.req_i = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        tests++; if ({bus.gnt_o, bus.rsp_valid_o, bus.rsp_root_o, bus.rsp_err_o, bus.core_start_o, bus.core_abort_o, bus.core_op_o} !== '0) begin
            fails++; $display("FAIL rmw_outputs got op %0d valid %b root %0d want all 0", bus.core_op_o, bus.rsp_valid_o, bus.rsp_root_o);
        end
        bus.core_done_i = 1'b1; bus.core_root_i = 4'd9;
        repeat (3) begin
            @(negedge clk);
            if (bus.gnt_o != 0 || bus.rsp_valid_o != 0 || bus.core_abort_o) bad = 1;
        end
        bus.core_done_i = 1'b0;
        rst = 1'b0;
        m_last = 1'b1;
        repeat (TO + 4) begin
            @(negedge clk);
            if (bus.gnt_o != 0 || bus.rsp_valid_o != 0 || bus.core_abort_o) bad = 1;
        end
        tests++; if (bad) begin fails++; $display("FAIL rmw_quiet got activity after reset want none"); end
        run_txn(2'b10, 8'd0, 8'd64, 0, 1, 0, 0, r);
        if (r.lost) return;
        tests++; if (r.gnt !== 2'b10 || r.root !== 4'd8) begin fails++; $display("FAIL rmw_next got gnt %b root %0d want 10 8", r.gnt, r.root); end
        m_last = 1'b1;
    endtask

    task automatic test_random();
        res_t r;
        logic [1:0] rq, want;
        logic [W-1:0] a, b, wop;
        int dly, ackd;
        for (int i = 0; i < 10; i++) begin
            rq   = 2'($urandom_range(1, 3));
            a    = 8'($urandom_range(0, 255));
            b    = 8'($urandom_range(0, 255));
            dly  = $urandom_range(0, 6);
            ackd = $urandom_range(0, 3);
            want = model_pick(rq);
            wop  = want[1] ? b : a;
            run_txn(rq, a, b, dly, ackd, 1'($urandom_range(0, 1)), 0, r);
            if (r.lost) continue;
            tests++; if (r.gnt !== want || r.op !== wop) begin fails++; $display("FAIL rnd_gnt[%0d] got gnt %b op %0d want %b %0d", i, r.gnt, r.op, want, wop); end
            tests++; if (r.root !== HW'(isqrt(int'(wop))) || r.err !== 1'b0 || r.valid !== want) begin
                fails++; $display("FAIL rnd_rsp[%0d] got root %0d err %b valid %b want %0d 0 %b", i, r.root, r.err, r.valid, isqrt(int'(wop)), want);
            end
            tests++; if (r.waits != dly + 1 || r.vcycles != ackd + 1 || !r.dropped) begin
                fails++; $display("FAIL rnd_timing[%0d] got waits %0d vcyc %0d dropped %0d want %0d %0d 1", i, r.waits, r.vcycles, r.dropped, dly + 1, ackd + 1);
            end
            m_last = want[1];
        end
    endtask

    initial begin
        bus.req_i = 0; bus.op0_i = 0; bus.op1_i = 0; bus.rsp_ack_i = 0;
        bus.core_done_i = 0; bus.core_root_i = 0;
        test_reset();
        test_tie();
        test_basic();
        test_alternate();
        test_timeout();
        test_ack_delay();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got no completion want finish before 400000");
        $fatal(1, "watchdog");
    end

endmodule
